// File: rtl/seq_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_if
//  Brief    : Start/Busy/Done request and result bundle for seq_div.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_div_if #(
    parameter int N = 8
);
    logic         Start;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivByZero;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivByZero
    );
endinterface
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Brief    : Iterative restoring divider, one quotient bit per clock.
//             Define SEQ_DIV_SIGNED_EN for two's-complement operands.
//  Revision : 1.0  initial release
// ============================================================================
module seq_div #(
    parameter int N = 8
) (
    input  logic     Clock,
    input  logic     Reset,
    seq_div_if.slave bus
);
    localparam int             CW     = $clog2(N + 1);
    localparam logic [CW-1:0]  c_last = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_rem, r_quo, r_dvs;
    logic [N-1:0]  r_q_out, r_r_out;
    logic          r_dbz;

    logic          w_accept, w_busy, w_done, w_last, w_dvs_zero;
    logic [N-1:0]  w_dvd_mag, w_dvs_mag;
    logic [N:0]    w_shift, w_diff;
    logic [N-1:0]  w_rem_nx, w_quo_nx;
    logic [N-1:0]  w_q_fin, w_r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic [N-1:0]  r_dvd;
    logic          r_qneg, r_rneg;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_last = (r_cnt == c_last);

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.Start;
                if (bus.Start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_FIN;
            end
            S_FIN: begin
                w_done   = 1'b1;
                w_accept = bus.Start;
                w_next   = bus.Start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SEQ_DIV_SIGNED_EN
    assign w_dvd_mag = bus.Dividend[N-1] ? -bus.Dividend : bus.Dividend;
    assign w_dvs_mag = bus.Divisor[N-1]  ? -bus.Divisor  : bus.Divisor;
`else
    assign w_dvd_mag = bus.Dividend;
    assign w_dvs_mag = bus.Divisor;
`endif

    // Remainder stays below the divisor, so the trial difference fits in N bits.
    assign w_shift  = {r_rem, r_quo[N-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_rem_nx = w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];
    assign w_quo_nx = {r_quo[N-2:0], ~w_diff[N]};

    assign w_dvs_zero = (r_dvs == '0);

`ifdef SEQ_DIV_SIGNED_EN
    assign w_q_fin = w_dvs_zero ? '1    : (r_qneg ? -r_quo : r_quo);
    assign w_r_fin = w_dvs_zero ? r_dvd : (r_rneg ? -r_rem : r_rem);
`else
    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign w_q_fin = r_quo;
    assign w_r_fin = r_rem;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_dvd   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= w_dvd_mag;
            r_dvs <= w_dvs_mag;
            r_dbz <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_dvd  <= bus.Dividend;
            r_qneg <= bus.Dividend[N-1] ^ bus.Divisor[N-1];
            r_rneg <= bus.Dividend[N-1];
`endif
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_q_out <= w_q_fin;
                r_r_out <= w_r_fin;
                r_dbz   <= w_dvs_zero;
            end else begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.Busy      = w_busy;
    assign bus.Done      = w_done;
    assign bus.Quotient  = r_q_out;
    assign bus.Remainder = r_r_out;
    assign bus.DivByZero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Brief    : Directed self-checking bench for seq_div (N = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_div;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   lat, bc, extra;

    seq_div_if #(.N(N)) bus ();
    seq_div    #(.N(N)) dut (.Clock(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with Start for one edge, then scramble the operand inputs.
    task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.Start    = 1'b1;
        bus.Dividend = a;
        bus.Divisor  = b;
        tick();
        bus.Start    = 1'b0;
        bus.Dividend = 8'hA5;
        bus.Divisor  = 8'h3C;
    endtask

    task automatic wait_done(output int l, output int busy_cnt);
        l        = -1;
        busy_cnt = bus.Busy ? 1 : 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (bus.Done) begin
                l = j;
                return;
            end
            if (bus.Busy) busy_cnt++;
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int j = 0; j < cycles; j++) begin
            tick();
            if (bus.Done) cnt++;
        end
    endtask

    initial begin
        bus.Start    = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_q", bus.Quotient, 0);
        chk("rst_r", bus.Remainder, 0);
        chk("rst_dbz", bus.DivByZero, 0);
        rst = 1'b0;
        tick();

        // 100 / 7
        do_start(8'd100, 8'd7);
        chk("t1_busy_next", bus.Busy, 1);
        wait_done(lat, bc);
        chk("t1_latency", lat, 9);
        chk("t1_busy_cycles", bc, 9);
        chk("t1_done_busy_low", bus.Busy, 0);
        chk("t1_q", bus.Quotient, 14);
        chk("t1_r", bus.Remainder, 2);
        chk("t1_dbz", bus.DivByZero, 0);
        tick();
        chk("t1_done_one_cycle", bus.Done, 0);
        chk("t1_q_held", bus.Quotient, 14);

`ifndef SEQ_DIV_SIGNED_EN
        // 255 / 1 followed by back-to-back 200 / 255 issued in FIN
        do_start(8'd255, 8'd1);
        wait_done(lat, bc);
        chk("t2a_latency", lat, 9);
        chk("t2a_q", bus.Quotient, 255);
        chk("t2a_r", bus.Remainder, 0);
        do_start(8'd200, 8'd255);
        chk("t2b_accepted_busy", bus.Busy, 1);
        wait_done(lat, bc);
        chk("t2b_latency", lat, 9);
        chk("t2b_q", bus.Quotient, 0);
        chk("t2b_r", bus.Remainder, 200);
        tick();
`endif

        // 37 / 0 then 10 / 3
        do_start(8'd37, 8'd0);
        wait_done(lat, bc);
        chk("t3_latency", lat, 9);
        chk("t3_q", bus.Quotient, 8'hFF);
        chk("t3_r", bus.Remainder, 37);
        chk("t3_dbz", bus.DivByZero, 1);
        tick();
        chk("t3_dbz_held", bus.DivByZero, 1);
        do_start(8'd10, 8'd3);
        chk("t3b_dbz_cleared", bus.DivByZero, 0);
        wait_done(lat, bc);
        chk("t3b_q", bus.Quotient, 3);
        chk("t3b_r", bus.Remainder, 1);
        chk("t3b_dbz", bus.DivByZero, 0);
        tick();

        // Start re-asserted on cycle 3 of RUN is ignored
        do_start(8'd100, 8'd7);
        tick();
        tick();
        do_start(8'd50, 8'd5);
        wait_done(lat, bc);
        chk("t4_latency", lat, 6);
        chk("t4_q", bus.Quotient, 14);
        chk("t4_r", bus.Remainder, 2);
        count_dones(14, extra);
        chk("t4_single_done", extra, 0);

        // Reset on cycle 4 of RUN aborts the division
        do_start(8'd100, 8'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", bus.Busy, 0);
        chk("t5_done", bus.Done, 0);
        chk("t5_q", bus.Quotient, 0);
        chk("t5_r", bus.Remainder, 0);
        chk("t5_dbz", bus.DivByZero, 0);
        tick();
        rst = 1'b0;
        count_dones(14, extra);
        chk("t5_no_done", extra, 0);
        do_start(8'd9, 8'd2);
        wait_done(lat, bc);
        chk("t5b_latency", lat, 9);
        chk("t5b_q", bus.Quotient, 4);
        chk("t5b_r", bus.Remainder, 1);
        tick();

`ifdef SEQ_DIV_SIGNED_EN
        do_start(8'h9C, 8'd7);
        wait_done(lat, bc);
        chk("s1_q", bus.Quotient, 8'hF2);
        chk("s1_r", bus.Remainder, 8'hFE);
        tick();
        do_start(8'h80, 8'hFF);
        wait_done(lat, bc);
        chk("s2_q", bus.Quotient, 8'h80);
        chk("s2_r", bus.Remainder, 8'h00);
        tick();
        do_start(8'd100, 8'hF9);
        wait_done(lat, bc);
        chk("s3_latency", lat, 9);
        chk("s3_q", bus.Quotient, 8'hF2);
        chk("s3_r", bus.Remainder, 8'h02);
        tick();
        do_start(8'hDB, 8'h00);
        wait_done(lat, bc);
        chk("s4_q", bus.Quotient, 8'hFF);
        chk("s4_r", bus.Remainder, 8'hDB);
        chk("s4_dbz", bus.DivByZero, 1);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
